// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - shared types for the instruction register and its write arbiter
package instr_register_pkg;

    typedef enum logic [2:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef enum logic [1:0] {
        IDLE, LOAD, FULL
    } arb_state_t;

    typedef logic req_id_t;

    localparam int INSTR_DEPTH = 32;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; last_grant moves only when advance is high
module rr_arb2
    import instr_register_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       advance,
    output logic [1:0] grant,
    output req_id_t    grant_id
);

    req_id_t last_grant_q;

    // On contention the requester that did not win last time gets the slot
    always_comb begin
        grant[0] = valid0 && (!valid1 || (last_grant_q == 1'b1));
        grant[1] = valid1 && (!valid0 || (last_grant_q == 1'b0));
        grant_id = grant[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else if (advance) begin
            last_grant_q <= grant_id;
        end
    end

endmodule

// File: rtl/instr_reg_write_arbiter.sv
// rtl/instr_reg_write_arbiter.sv - shares the instr_register write port between two producers
module instr_reg_write_arbiter
    import instr_register_pkg::*;
#(
    parameter int DEPTH   = INSTR_DEPTH,
    parameter bit WRAP_EN = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       req0_valid,
    input  opcode_t                    req0_opcode,
    input  operand_t                   req0_operand_a,
    input  operand_t                   req0_operand_b,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  opcode_t                    req1_opcode,
    input  operand_t                   req1_operand_a,
    input  operand_t                   req1_operand_b,
    output logic                       req1_ready,
    output logic                       load_en,
    output address_t                   write_pointer,
    output opcode_t                    opcode,
    output operand_t                   operand_a,
    output operand_t                   operand_b,
    output req_id_t                    grant_id,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int CW = $clog2(DEPTH + 1);

    arb_state_t    state_q, state_d;
    address_t      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          load_en_q;
    address_t      write_pointer_q;
    opcode_t       opcode_q;
    operand_t      operand_a_q, operand_b_q;
    req_id_t       grant_id_q;

    logic [1:0]    grant;
    req_id_t       arb_id;
    logic          accept_ok;
    logic          handshake;

    assign accept_ok = !flush && (state_q != FULL);
    assign handshake = accept_ok && (req0_valid || req1_valid);

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .advance  (handshake),
        .grant    (grant),
        .grant_id (arb_id)
    );

    assign req0_ready = accept_ok && grant[0];
    assign req1_ready = accept_ok && grant[1];

    // Pointer wraps naturally because DEPTH equals 2**$bits(address_t)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (handshake) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q != CW'(DEPTH)) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, LOAD: begin
                if (handshake) begin
                    state_d = (!WRAP_EN && (count_d == CW'(DEPTH))) ? FULL : LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            FULL:    state_d = FULL;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            load_en_q       <= 1'b0;
            write_pointer_q <= '0;
            opcode_q        <= ZERO;
            operand_a_q     <= '0;
            operand_b_q     <= '0;
            grant_id_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            load_en_q <= handshake;
            // Write-port fields hold their last value between strobes
            if (handshake) begin
                write_pointer_q <= wr_ptr_q;
                grant_id_q      <= arb_id;
                opcode_q        <= arb_id ? req1_opcode    : req0_opcode;
                operand_a_q     <= arb_id ? req1_operand_a : req0_operand_a;
                operand_b_q     <= arb_id ? req1_operand_b : req0_operand_b;
            end
        end
    end

    assign load_en       = load_en_q;
    assign write_pointer = write_pointer_q;
    assign opcode        = opcode_q;
    assign operand_a     = operand_a_q;
    assign operand_b     = operand_b_q;
    assign grant_id      = grant_id_q;
    assign count         = count_q;
    assign full          = (state_q == FULL);

endmodule
